// File: rtl/alu_mul_sequencer_if.sv
// Request/response bundle between a client and the multiply sequencer.
// Client drives start_i and the operands; sequencer returns busy_o, done_o, product_o.
interface alu_mul_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [DATA_WIDTH-1:0] multiplicand_i;
    logic [DATA_WIDTH-1:0] multiplier_i;
    logic                  busy_o;
    logic                  done_o;
    logic [DATA_WIDTH-1:0] product_o;

    modport master (
        output start_i,
        output multiplicand_i,
        output multiplier_i,
        input  busy_o,
        input  done_o,
        input  product_o
    );

    modport slave (
        input  start_i,
        input  multiplicand_i,
        input  multiplier_i,
        output busy_o,
        output done_o,
        output product_o
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows the shared ALU for every step (low 32 bits of A*B).
// Ports: clk, reset (sync, active-low), bus (request/result), alu_result_i/alu_zero_i in, alu_op_o/alu_a_o/alu_b_o out.
module alu_mul_sequencer #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] OP_ADD     = 4'b0000,
    parameter logic [3:0] OP_SLL     = 4'b0011,
    parameter logic [3:0] OP_SRL     = 4'b0100
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_mul_sequencer_if.slave    bus,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic                  alu_zero_i,
    output logic [3:0]            alu_op_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'd31;

    state_t                state;
    state_t                state_nx;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] mc;
    logic [DATA_WIDTH-1:0] mp;
    logic [5:0]            cnt;
    logic [DATA_WIDTH-1:0] product;

    assign bus.busy_o    = (state != S_IDLE);
    assign bus.done_o    = (state == S_DONE);
    assign bus.product_o = product;

    always_comb begin
        state_nx = state;
        alu_op_o = OP_ADD;
        alu_a_o  = '0;
        alu_b_o  = '0;
        case (state)
            S_IDLE: begin
                if (bus.start_i) begin
                    if (bus.multiplier_i == '0) begin
                        state_nx = S_DONE;
                    end else if (bus.multiplier_i[0]) begin
                        state_nx = S_ADD;
                    end else begin
                        state_nx = S_SHL;
                    end
                end
            end
            S_ADD: begin
                alu_op_o = OP_ADD;
                alu_a_o  = acc;
                alu_b_o  = mc;
                state_nx = S_SHL;
            end
            S_SHL: begin
                alu_op_o = OP_SLL;
                alu_a_o  = mc;
                alu_b_o  = DATA_WIDTH'(1);
                state_nx = S_SHR;
            end
            S_SHR: begin
                alu_op_o = OP_SRL;
                alu_a_o  = mp;
                alu_b_o  = DATA_WIDTH'(1);
                // Zero flag on the shifted multiplier means no set bits remain.
                if (alu_zero_i || cnt == CNT_LAST) begin
                    state_nx = S_DONE;
                end else if (alu_result_i[0]) begin
                    state_nx = S_ADD;
                end else begin
                    state_nx = S_SHL;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            acc     <= '0;
            mc      <= '0;
            mp      <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        acc <= '0;
                        mc  <= bus.multiplicand_i;
                        mp  <= bus.multiplier_i;
                        cnt <= '0;
                    end
                end
                S_ADD: acc <= alu_result_i;
                S_SHL: mc  <= alu_result_i;
                S_SHR: begin
                    mp  <= alu_result_i;
                    cnt <= cnt + 6'd1;
                end
                default: ;
            endcase
            // A zero multiplier skips the loop, so acc still holds the
            // previous run and must not be published.
            if (state_nx == S_DONE) begin
                product <= (state == S_IDLE) ? '0 : acc;
            end
        end
    end
endmodule
